fp_add_scheduler: RTL and testbench
===================================

# fp_add_scheduler

Round-robin scheduler that shares one fixed-latency pipelined single-precision floating-point adder among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the adder. Each issue is tagged with its requester ID in a shadow pipeline, and the adder result is routed back to the originating requester. It sits between client blocks and the SPFP adder datapath, and it is the only block that drives the adder's operand inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `LATENCY`, 5: adder pipeline depth in cycles, from operands presented to sum valid.
- `MAX_OUT`, 3: maximum in-flight operations per requester (1..7).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has an operand pair.
- `req_ready`  out  N_REQ  one-hot grant; the pair is accepted on the edge where `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  32*N_REQ  IEEE-754 operands; requester i uses bits [32i+31:32i].
- `add_valid`  out  1  the operand pair to the adder is valid this cycle.
- `add_a`, `add_b`  out  32  operands to the adder.
- `add_sum`  in  32  adder result, sampled `LATENCY` cycles after the matching `add_valid`.
- `resp_valid`  out  N_REQ  one-hot; the result for requester i is on `resp_data`.
- `resp_data`  out  32  result word, broadcast to all requesters.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and `out_cnt[i] < MAX_OUT`.
- **Grant:**
  - Combinationally pick the first eligible i, starting at `rr_ptr` and wrapping modulo `N_REQ`.
  - `req_ready` is one-hot on that i, and all-zero if nobody is eligible.
  - `req_ready` depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **Pointer:** on an accepted handshake, `rr_ptr <= (granted+1) mod N_REQ`. Otherwise `rr_ptr` holds.
- **Issue register:** on a handshake, `add_a/add_b <=` the granted operands, `add_valid <= 1`, and `tag_pipe[0] <= {1, granted_id}`. Otherwise `add_valid <= 0` and `tag_pipe[0] <= {0, x}`. `add_a/add_b` hold their last value.
- **Tag pipeline:** `LATENCY` stages of `{valid, id}`, shifting every cycle with no stall. The adder has no backpressure, so the scheduler never stalls.
- **Retire:** when stage `LATENCY-1` is valid, next cycle `resp_valid[id] <= 1` and `resp_data <= add_sum`. Otherwise `resp_valid <= 0` and `resp_data` holds.
- **Outstanding counters `out_cnt[i]`** (3 bits):
  - +1 on issue for i.
  - −1 on retire for i.
  - Unchanged when issue and retire for i happen in the same cycle.
  - Never exceeds `MAX_OUT` and never underflows. The verifier asserts both.
- **Responses:** requesters must always accept responses; there is no response ready.

## Timing
- **Reset values:** on `rst`, `req_ready` = 0 for that cycle (combinationally gated by `rst`), `add_valid` = 0, `add_a` = `add_b` = 0, `resp_valid` = 0, `resp_data` = 0, all tag stages invalid, all `out_cnt` = 0, `rr_ptr` = 0.
- **Reset mid-operation:** in-flight tags are discarded. Results still emerging from the adder produce no `resp_valid`.
- **Latency:** handshake on edge k → `add_valid` high in cycle k+1 → `add_sum` consumed in cycle k+1+LATENCY → `resp_valid` high in cycle k+2+LATENCY, i.e. `LATENCY+2` cycles.
- **Throughput:** one issue per cycle sustained across requesters. A single requester sustains `MAX_OUT` per `LATENCY+2` cycles when `MAX_OUT < LATENCY+2`.
- **Wrap-around:** the pointer after granting `N_REQ-1` is 0.
- **Edge cases:**
  - A requester at `MAX_OUT` is skipped, not blocked on; the next eligible requester is granted the same cycle.
  - A requester at `MAX_OUT` whose retire occurs this cycle is still ineligible this cycle, because eligibility uses the registered count.

## Structure
- **Package `fp_sched_pkg`:** `FP_W = 32`, the `tag_t` struct `{logic valid; logic [2:0] id;}`, and the default `LATENCY`/`MAX_OUT` constants.
- **Sub-module `rr_arbiter`** (parameter `N`): inputs `eligible[N]` and `ptr`; outputs `grant` (one-hot) and `grant_id`. It is purely combinational; the pointer register stays in the top level.
- **Top level:** issue register, tag shift register, counters, response register.

## Test plan
1. **Reset:** assert `rst` for 2 cycles with all `req_valid` high → `req_ready`, `add_valid`, `resp_valid` all 0; first grant to requester 0 in the first cycle after reset deasserts.
2. **Single op:** req0 issues a = 0x3F800000, b = 0x40000000 on edge k; the adder model returns 0x40400000 → `resp_valid` = 0001, `resp_data` = 0x40400000 at cycle k+7 (LATENCY = 5).
3. **Round-robin fairness:** all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3 with an issue every cycle; each response returns to the correct ID in order.
4. **Credit limit:** only req2 valid continuously, MAX_OUT = 3 → 3 back-to-back issues, `req_ready[2]` low for 4 cycles, then issues resume one cycle after each retire.
5. **Skip at limit:** req1 at MAX_OUT and req1, req3 valid with `rr_ptr` = 1 → req3 granted the same cycle and `rr_ptr` becomes 0.
6. **Mid-flight reset:** pulse `rst` 2 cycles after 3 issues → no `resp_valid` ever for those ops, counters 0, and a new issue afterwards returns normally.

Source files
------------

// File: rtl/fp_add_scheduler_pkg.sv
// Shared types and constants for the round-robin FP adder scheduler.
// The tag carries the requester ID alongside each operation in flight.
package fp_sched_pkg;

  localparam int FP_W        = 32;
  localparam int ID_W        = 3;
  localparam int CNT_W       = 3;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_LATENCY = 5;
  localparam int DEF_MAX_OUT = 3;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Next round-robin start position after granting v, wrapping at n.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
    return (int'(v) == n - 1) ? '0 : v + ID_W'(1);
  endfunction

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Requester handshake, adder operand/result and response signals in one bundle.
// The scheduler takes the slave view; clients plus the adder take the master view.
interface fp_add_scheduler_if import fp_sched_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ
);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [FP_W*N_REQ-1:0] req_a;
  logic [FP_W*N_REQ-1:0] req_b;
  logic                  add_valid;
  fp_word_t              add_a;
  fp_word_t              add_b;
  fp_word_t              add_sum;
  logic [N_REQ-1:0]      resp_valid;
  fp_word_t              resp_data;

  modport master (
    output req_valid, req_a, req_b, add_sum,
    input  req_ready, add_valid, add_a, add_b, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, add_sum,
    output req_ready, add_valid, add_a, add_b, resp_valid, resp_data
  );

endinterface

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping.
// The pointer itself is owned by the caller.
module rr_arbiter import fp_sched_pkg::*; #(
  parameter int N = DEF_N_REQ
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic found;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path infers a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && eligible[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency FP adder among N_REQ requesters with per-requester credits.
// A tag shadow pipeline routes each sum back to the requester that issued it.
module fp_add_scheduler import fp_sched_pkg::*; #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int LATENCY = DEF_LATENCY,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input logic               clk,
  input logic               rst,
  fp_add_scheduler_if.slave bus
);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             issue;
  fp_word_t         sel_a;
  fp_word_t         sel_b;
  logic             retire;
  logic [ID_W-1:0]  retire_id;
  logic [N_REQ-1:0] issue_hit;
  logic [N_REQ-1:0] retire_hit;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  fp_word_t         add_a_q, add_a_d;
  fp_word_t         add_b_q, add_b_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  fp_word_t         resp_data_q, resp_data_d;
  logic [CNT_W-1:0] out_cnt_q [N_REQ];
  logic [CNT_W-1:0] out_cnt_d [N_REQ];

  // Stage 0 is aligned with add_valid; stage LATENCY is aligned with add_sum.
  tag_t tag_q [LATENCY+1];
  tag_t tag_d [LATENCY+1];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (out_cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign issue         = !rst && (|grant);
  assign bus.req_ready = rst ? '0 : grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*FP_W +: FP_W];
        sel_b = bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

  assign retire    = tag_q[LATENCY].valid;
  assign retire_id = tag_q[LATENCY].id;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      issue_hit[i]  = issue && grant[i];
      retire_hit[i] = retire && (retire_id == ID_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    resp_valid_d = retire_hit;
    resp_data_d  = resp_data_q;

    tag_d[0].valid = issue;
    tag_d[0].id    = grant_id;
    for (int s = 1; s <= LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    if (issue) begin
      rr_ptr_d = wrap_inc(grant_id, N_REQ);
      add_a_d  = sel_a;
      add_b_d  = sel_b;
    end

    if (retire) begin
      resp_data_d = bus.add_sum;
    end

    // Same-cycle issue and retire for one requester cancel out.
    for (int i = 0; i < N_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (issue_hit[i] && !retire_hit[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
      end else if (retire_hit[i] && !issue_hit[i]) begin
        out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      // NOTE: every tag stage is cleared; a stale valid bit would retire a phantom op after reset.
      for (int s = 0; s <= LATENCY; s++) begin
        tag_q[s] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
      for (int i = 0; i < N_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  assign bus.add_valid  = tag_q[0].valid;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed plus random stimulus for fp_add_scheduler against a transaction-level model:
// a credit table, a rotating start index and a queue of expected responses.
module tb_fp_add_scheduler;
  import fp_sched_pkg::*;

  localparam int N    = 4;
  localparam int LAT  = 5;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_scheduler_if #(.N_REQ(N)) bus ();

  fp_add_scheduler #(.N_REQ(N), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Float helpers: single <-> double via bit repacking, exact for the integer operands used.
  function automatic real sp_to_real(input logic [31:0] s);
    logic [63:0] d;
    logic [10:0] e;
    if (s[30:0] == 31'd0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    d = {s[31], e, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real_to_sp(sp_to_real(a) + sp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    int v;
    v = int'($urandom_range(4000, 0)) - 2000;
    return real_to_sp($itor(v));
  endfunction

  // Adder: sum of operands presented LAT cycles earlier.
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= fadd(bus.add_a, bus.add_b);
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign bus.add_sum = apipe[LAT-1];

  // Reference model state.
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          m_ptr;
  int          m_cnt [N];
  int          cyc;
  logic        e_add_valid;
  logic [31:0] e_add_a, e_add_b, e_resp_data;
  logic [N-1:0] e_resp_valid;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i] && m_cnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = rand_fp();
      bus.req_b[i*32 +: 32] = rand_fp();
    end
  endtask

  // One clock: inputs already driven at the falling edge; check grant, clock, check outputs.
  task automatic step();
    int           g;
    logic [N-1:0] exp_ready;
    logic [31:0]  ga, gb;
    g         = rst ? -1 : model_grant();
    exp_ready = '0;
    ga        = '0;
    gb        = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      ga = bus.req_a[g*32 +: 32];
      gb = bus.req_b[g*32 +: 32];
    end
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      e_add_valid  = 1'b0;
      e_add_a      = '0;
      e_add_b      = '0;
      e_resp_valid = '0;
      e_resp_data  = '0;
    end else begin
      e_resp_valid = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_resp_valid[pend[0].id] = 1'b1;
        e_resp_data = pend[0].data;
        m_cnt[pend[0].id]--;
        void'(pend.pop_front());
      end
      e_add_valid = (g >= 0);
      if (g >= 0) begin
        e_add_a = ga;
        e_add_b = gb;
        pend.push_back('{id: g, data: fadd(ga, gb), due: cyc + LAT + 1});
        m_cnt[g]++;
        m_ptr = (g + 1) % N;
      end
    end
    #1;
    check("add_valid", 32'(bus.add_valid), 32'(e_add_valid));
    check("add_a", bus.add_a, e_add_a);
    check("add_b", bus.add_b, e_add_b);
    check("resp_valid", 32'(bus.resp_valid), 32'(e_resp_valid));
    check("resp_data", bus.resp_data, e_resp_data);
    @(negedge clk);
  endtask

  task automatic run(input logic [N-1:0] v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive(v);
      step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    e_add_valid  = 1'b0;
    e_add_a      = '0;
    e_add_b      = '0;
    e_resp_valid = '0;
    e_resp_data  = '0;

    // Reset with every requester asserting valid; first grant afterwards goes to 0.
    rst = 1'b1;
    drive('1);
    @(negedge clk);
    run('1, 2);
    rst = 1'b0;
    run('1, 1);
    run('0, 10);

    // Single op from requester 0: 1.0 + 2.0 returns 3.0 seven cycles later.
    bus.req_valid = 4'b0001;
    bus.req_a[31:0] = 32'h3F80_0000;
    bus.req_b[31:0] = 32'h4000_0000;
    step();
    run('0, 6);
    check("single_resp_valid", 32'(bus.resp_valid), 32'h0000_0001);
    check("single_resp_data", bus.resp_data, 32'h4040_0000);
    run('0, 4);

    // All requesters continuously valid: strict rotation, one issue per cycle.
    run('1, 8);
    run('0, 10);

    // Only requester 2: three back-to-back issues then credit-limited.
    run(4'b0100, 20);
    run('0, 10);

    // Requester 1 at its limit with pointer at 1: requester 3 granted the same cycle.
    run(4'b0010, 3);
    run(4'b0001, 1);
    drive(4'b1010);
    #1;
    check("skip_full_ready", 32'(bus.req_ready), 32'h0000_0008);
    step();
    run(4'b1010, 3);
    run('0, 10);

    // Reset two cycles after three issues: those ops never respond.
    run('1, 3);
    run('0, 2);
    rst = 1'b1;
    run('0, 1);
    rst = 1'b0;
    run('0, 10);
    run(4'b0001, 1);
    run('0, 10);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(99, 0) < 2);
      drive(N'($urandom));
      step();
    end
    rst = 1'b0;
    run('0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
